// File: rtl/tank_pkg.sv
// Shared types and helpers for the tank motion controller.
// Coordinates are 7-bit unsigned and wrap mod 128.
package tank_pkg;

    typedef logic [6:0] coord_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUERY,
        ST_WAIT,
        ST_COOL
    } state_t;

    localparam int SPRITE_HALF = 2;
    localparam int BULLET_OFS  = 3;
    localparam int CD_W        = 8;

    function automatic coord_t step_x(coord_t x, dir_t d, coord_t n);
        case (d)
            DIR_LEFT:  return x - n;
            DIR_RIGHT: return x + n;
            default:   return x;
        endcase
    endfunction

    function automatic coord_t step_y(coord_t y, dir_t d, coord_t n);
        case (d)
            DIR_UP:   return y - n;
            DIR_DOWN: return y + n;
            default:  return y;
        endcase
    endfunction

endpackage

// File: rtl/tank_motion_ctrl_tick_cooldown.sv
// Tick-driven down-counter: load has priority, otherwise decrements on
// each tick and saturates at zero.
module tick_cooldown #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_tick,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/tank_motion_ctrl.sv
// Per-tank motion sequencer: turn, bounds check, map query, move, cooldown,
// plus an independent bullet-spawn request path.
module tank_motion_ctrl
    import tank_pkg::*;
#(
    parameter int FIELD_W  = 64,
    parameter int FIELD_H  = 48,
    parameter int INIT_X   = 10,
    parameter int INIT_Y   = 10,
    parameter int INIT_DIR = 0,
    parameter int MOVE_CD  = 2,
    parameter int TURN_CD  = 1,
    parameter int FIRE_CD  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_cmd_valid,
    input  logic [1:0] i_cmd_dir,
    input  logic       i_fire,
    output logic       o_query_valid,
    output logic [6:0] o_query_x,
    output logic [6:0] o_query_y,
    input  logic       i_query_ready,
    input  logic       i_resp_valid,
    input  logic       i_resp_free,
    output logic       o_bullet_req,
    output logic [6:0] o_bullet_x,
    output logic [6:0] o_bullet_y,
    output logic [1:0] o_bullet_dir,
    input  logic       i_bullet_ack,
    output logic [6:0] o_tank_x,
    output logic [6:0] o_tank_y,
    output logic [1:0] o_tank_dir,
    output logic       o_blocked
);

    localparam coord_t X_MIN = coord_t'(SPRITE_HALF);
    localparam coord_t X_MAX = coord_t'(FIELD_W - 1 - SPRITE_HALF);
    localparam coord_t Y_MIN = coord_t'(SPRITE_HALF);
    localparam coord_t Y_MAX = coord_t'(FIELD_H - 1 - SPRITE_HALF);
    // The firing tick itself counts as the first of the FIRE_CD ticks.
    localparam logic [CD_W-1:0] FIRE_LOAD = (FIRE_CD > 0) ? CD_W'(FIRE_CD - 1) : '0;

    state_t state_q, state_d;
    coord_t x_q, x_d, y_q, y_d, qx_q, qx_d, qy_q, qy_d;
    coord_t bx_q, bx_d, by_q, by_d;
    dir_t   dir_q, dir_d, bdir_q, bdir_d;
    logic   blocked_q, blocked_d, breq_q, breq_d;

    logic            cmd_tick, turn, step, can_move, fire_go;
    logic            move_load, move_zero, fire_zero;
    logic [CD_W-1:0] move_load_val;

    assign cmd_tick = (state_q == ST_IDLE) && i_tick && i_cmd_valid;
    assign turn     = cmd_tick && (dir_t'(i_cmd_dir) != dir_q);
    assign step     = cmd_tick && !turn;
    assign fire_go  = i_tick && i_fire && fire_zero && !breq_q;

    always_comb begin
        case (dir_q)
            DIR_UP:   can_move = (y_q > Y_MIN);
            DIR_DOWN: can_move = (y_q < Y_MAX);
            DIR_LEFT: can_move = (x_q > X_MIN);
            default:  can_move = (x_q < X_MAX);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (turn) begin
                    state_d = (TURN_CD == 0) ? ST_IDLE : ST_COOL;
                end else if (step && can_move) begin
                    state_d = ST_QUERY;
                end
            end
            ST_QUERY: if (i_query_ready) state_d = ST_WAIT;
            ST_WAIT:  if (i_resp_valid) state_d = (MOVE_CD == 0) ? ST_IDLE : ST_COOL;
            default:  if (move_zero) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_query_valid = (state_q == ST_QUERY);
    end

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        dir_d         = dir_q;
        qx_d          = qx_q;
        qy_d          = qy_q;
        blocked_d     = 1'b0;
        move_load     = 1'b0;
        move_load_val = '0;
        breq_d        = breq_q;
        bx_d          = bx_q;
        by_d          = by_q;
        bdir_d        = bdir_q;

        if (turn) begin
            dir_d         = dir_t'(i_cmd_dir);
            move_load     = 1'b1;
            move_load_val = CD_W'(TURN_CD);
        end
        if (step) begin
            if (can_move) begin
                qx_d = step_x(x_q, dir_q, 7'd1);
                qy_d = step_y(y_q, dir_q, 7'd1);
            end else begin
                blocked_d = 1'b1;
            end
        end
        if ((state_q == ST_WAIT) && i_resp_valid) begin
            move_load     = 1'b1;
            move_load_val = CD_W'(MOVE_CD);
            if (i_resp_free) begin
                x_d = qx_q;
                y_d = qy_q;
            end else begin
                blocked_d = 1'b1;
            end
        end

        // Spawn point uses the pre-commit position/direction of this cycle.
        if (fire_go) begin
            breq_d = 1'b1;
            bx_d   = step_x(x_q, dir_q, coord_t'(BULLET_OFS));
            by_d   = step_y(y_q, dir_q, coord_t'(BULLET_OFS));
            bdir_d = dir_q;
        end else if (breq_q && i_bullet_ack) begin
            breq_d = 1'b0;
            bx_d   = '0;
            by_d   = '0;
            bdir_d = DIR_UP;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            x_q       <= coord_t'(INIT_X);
            y_q       <= coord_t'(INIT_Y);
            dir_q     <= dir_t'(INIT_DIR);
            qx_q      <= '0;
            qy_q      <= '0;
            blocked_q <= 1'b0;
            breq_q    <= 1'b0;
            bx_q      <= '0;
            by_q      <= '0;
            bdir_q    <= DIR_UP;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
            qx_q      <= qx_d;
            qy_q      <= qy_d;
            blocked_q <= blocked_d;
            breq_q    <= breq_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            bdir_q    <= bdir_d;
        end
    end

    tick_cooldown #(.W(CD_W)) u_move_cd (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_tick     (i_tick),
        .i_load     (move_load),
        .i_load_val (move_load_val),
        .o_zero     (move_zero)
    );

    tick_cooldown #(.W(CD_W)) u_fire_cd (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_tick     (i_tick),
        .i_load     (fire_go),
        .i_load_val (FIRE_LOAD),
        .o_zero     (fire_zero)
    );

    assign o_query_x    = qx_q;
    assign o_query_y    = qy_q;
    assign o_bullet_req = breq_q;
    assign o_bullet_x   = bx_q;
    assign o_bullet_y   = by_q;
    assign o_bullet_dir = bdir_q;
    assign o_tank_x     = x_q;
    assign o_tank_y     = y_q;
    assign o_tank_dir   = dir_q;
    assign o_blocked    = blocked_q;

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Directed bench for tank_motion_ctrl with a behavioural reference model
// compared on every cycle, plus hand-computed spot values.
module tb_tank_motion_ctrl;

    localparam int FW = 64, FH = 48, CD_MOVE = 2, CD_TURN = 1, CD_FIRE = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, tick = 1'b0, cmd_valid = 1'b0, fire = 1'b0;
    logic [1:0] cmd_dir = 2'd0;
    logic       query_ready = 1'b0, resp_valid = 1'b0, resp_free = 1'b0, bullet_ack = 1'b0;
    logic       qv, breq, blk;
    logic [6:0] qx, qy, bx, by, tx, ty;
    logic [1:0] bd, tdir;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tank_motion_ctrl dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_tick        (tick),
        .i_cmd_valid   (cmd_valid),
        .i_cmd_dir     (cmd_dir),
        .i_fire        (fire),
        .o_query_valid (qv),
        .o_query_x     (qx),
        .o_query_y     (qy),
        .i_query_ready (query_ready),
        .i_resp_valid  (resp_valid),
        .i_resp_free   (resp_free),
        .o_bullet_req  (breq),
        .o_bullet_x    (bx),
        .o_bullet_y    (by),
        .o_bullet_dir  (bd),
        .i_bullet_ack  (bullet_ack),
        .o_tank_x      (tx),
        .o_tank_y      (ty),
        .o_tank_dir    (tdir),
        .o_blocked     (blk)
    );

    // Reference model: phase 0 free, 1 asking map, 2 awaiting answer, 3 resting.
    int m_x, m_y, m_dir, m_phase, m_rest, m_qx, m_qy, m_since, m_bx, m_by, m_bd;
    bit m_breq, m_blk;
    bit m_live = 1'b0;

    function automatic int dx_of(int d);
        return (d == 3) ? 1 : ((d == 2) ? -1 : 0);
    endfunction

    function automatic int dy_of(int d);
        return (d == 1) ? 1 : ((d == 0) ? -1 : 0);
    endfunction

    task automatic model_step();
        int nx, ny;
        if (!rst_n) begin
            m_x = 10; m_y = 10; m_dir = 0; m_phase = 0; m_rest = 0;
            m_qx = 0; m_qy = 0; m_since = CD_FIRE; m_breq = 0;
            m_bx = 0; m_by = 0; m_bd = 0; m_blk = 0; m_live = 1'b1;
            return;
        end
        if (!m_live) return;
        m_blk = 0;
        if (tick) m_since = (m_since < 255) ? m_since + 1 : 255;
        if (tick && fire && !m_breq && m_since >= CD_FIRE) begin
            m_breq = 1; m_since = 0; m_bd = m_dir;
            m_bx = (m_x + 3 * dx_of(m_dir)) & 127;
            m_by = (m_y + 3 * dy_of(m_dir)) & 127;
        end else if (m_breq && bullet_ack) begin
            m_breq = 0; m_bx = 0; m_by = 0; m_bd = 0;
        end
        case (m_phase)
            0: if (tick && cmd_valid) begin
                if (int'(cmd_dir) != m_dir) begin
                    m_dir = int'(cmd_dir);
                    m_rest = CD_TURN;
                    m_phase = (m_rest > 0) ? 3 : 0;
                end else begin
                    nx = m_x + dx_of(m_dir);
                    ny = m_y + dy_of(m_dir);
                    if (nx < 2 || nx > FW - 3 || ny < 2 || ny > FH - 3) begin
                        m_blk = 1;
                    end else begin
                        m_qx = nx; m_qy = ny; m_phase = 1;
                    end
                end
            end
            1: if (query_ready) m_phase = 2;
            2: if (resp_valid) begin
                if (resp_free) begin
                    m_x = m_qx; m_y = m_qy;
                end else begin
                    m_blk = 1;
                end
                m_rest = CD_MOVE;
                m_phase = (m_rest > 0) ? 3 : 0;
            end
            default: begin
                if (m_rest == 0) m_phase = 0;
                else if (tick) m_rest = m_rest - 1;
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            total++;
            if (int'(tx) != m_x || int'(ty) != m_y || int'(tdir) != m_dir ||
                qv != (m_phase == 1) || int'(qx) != m_qx || int'(qy) != m_qy ||
                breq != m_breq || int'(bx) != m_bx || int'(by) != m_by ||
                int'(bd) != m_bd || blk != m_blk) begin
                bad++;
                $display("FAIL model t=%0t got tank=%0d,%0d,%0d q=%0b,%0d,%0d b=%0b,%0d,%0d,%0d blk=%0b want tank=%0d,%0d,%0d q=%0b,%0d,%0d b=%0b,%0d,%0d,%0d blk=%0b",
                         $time, tx, ty, tdir, qv, qx, qy, breq, bx, by, bd, blk,
                         m_x, m_y, m_dir, (m_phase == 1), m_qx, m_qy, m_breq, m_bx, m_by, m_bd, m_blk);
            end
        end
    end

    task automatic chk(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; tick = 0; cmd_valid = 0; fire = 0; query_ready = 0;
        resp_valid = 0; bullet_ack = 0;
        step(3);
        rst_n = 1;
        step();
    endtask

    task automatic pulse_tick();
        tick = 1; step(); tick = 0; step(2);
    endtask

    task automatic move(int d, bit free);
        cmd_valid = 1; cmd_dir = 2'(d);
        tick = 1; step(); tick = 0; cmd_valid = 0;
        for (int k = 0; k < 4 && !qv; k++) step();
        if (qv) begin
            query_ready = 1; step(); query_ready = 0;
            resp_valid = 1; resp_free = free; step(); resp_valid = 0;
        end
        repeat (3) pulse_tick();
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_x", int'(tx), 10);
        chk("rst_y", int'(ty), 10);
        chk("rst_dir", int'(tdir), 0);
        chk("rst_qv", int'(qv), 0);
        chk("rst_breq", int'(breq), 0);
        chk("rst_blk", int'(blk), 0);

        // Turn, then one ignored tick, then accepted move with stalled ready
        cmd_valid = 1; cmd_dir = 2'd3;
        tick = 1; step(); tick = 0;
        chk("turn_dir", int'(tdir), 3);
        chk("turn_noq", int'(qv), 0);
        step(2);
        tick = 1; step(); tick = 0;
        chk("turn_cd_ignore", int'(qv), 0);
        step(2);
        tick = 1; step(); tick = 0; cmd_valid = 0;
        chk("move_qv", int'(qv), 1);
        chk("move_qx", int'(qx), 11);
        chk("move_qy", int'(qy), 10);
        step(5);
        chk("move_q_hold", int'(qv), 1);
        chk("move_qx_hold", int'(qx), 11);
        query_ready = 1; step(); query_ready = 0;
        chk("wait_noq", int'(qv), 0);
        resp_valid = 1; resp_free = 1; step(); resp_valid = 0;
        chk("commit_x", int'(tx), 11);

        // Move cooldown: two ticks ignored, third accepted; map refuses it
        cmd_valid = 1; cmd_dir = 2'd3;
        tick = 1; step(); tick = 0;
        chk("mcd1", int'(qv), 0);
        step(2);
        tick = 1; step(); tick = 0;
        chk("mcd2", int'(qv), 0);
        step(2);
        tick = 1; step(); tick = 0; cmd_valid = 0;
        chk("mcd_accept_qx", int'(qx), 12);
        query_ready = 1; step(); query_ready = 0;
        resp_valid = 1; resp_free = 0; step(); resp_valid = 0;
        chk("map_blk", int'(blk), 1);
        chk("map_blk_x", int'(tx), 11);
        step();
        chk("map_blk_pulse", int'(blk), 0);
        repeat (3) pulse_tick();

        // Walk left to the x = 2 boundary, then bump it
        move(2, 1'b1);
        for (int i = 0; i < 9; i++) move(2, 1'b1);
        chk("edge_x", int'(tx), 2);
        cmd_valid = 1; cmd_dir = 2'd2;
        tick = 1; step(); tick = 0; cmd_valid = 0;
        chk("edge_blk", int'(blk), 1);
        chk("edge_noq", int'(qv), 0);
        step();
        chk("edge_blk_pulse", int'(blk), 0);
        chk("edge_x_keep", int'(tx), 2);

        // Fire path and fire cooldown
        do_reset();
        fire = 1;
        tick = 1; step(); tick = 0;
        chk("fire_req", int'(breq), 1);
        chk("fire_bx", int'(bx), 10);
        chk("fire_by", int'(by), 7);
        chk("fire_bd", int'(bd), 0);
        step(3);
        chk("fire_hold", int'(breq), 1);
        bullet_ack = 1; step(); bullet_ack = 0;
        chk("fire_ack_drop", int'(breq), 0);
        for (int k = 1; k < 8; k++) begin
            tick = 1; step(); tick = 0;
            chk("fire_cd_block", int'(breq), 0);
            step(2);
        end
        cmd_valid = 1; cmd_dir = 2'd2;
        tick = 1; step(); tick = 0; cmd_valid = 0; fire = 0;
        chk("fire8_req", int'(breq), 1);
        chk("fire8_bd_pre_turn", int'(bd), 0);
        chk("fire8_tank_dir", int'(tdir), 2);
        bullet_ack = 1; step(); bullet_ack = 0;
        chk("fire8_ack", int'(breq), 0);
        step(3);

        // Reset while awaiting the map response
        do_reset();
        cmd_valid = 1; cmd_dir = 2'd0;
        tick = 1; step(); tick = 0; cmd_valid = 0;
        chk("r6_qy", int'(qy), 9);
        query_ready = 1; step(); query_ready = 0;
        rst_n = 0; step();
        chk("r6_qv_drop", int'(qv), 0);
        chk("r6_y_init", int'(ty), 10);
        rst_n = 1;
        resp_valid = 1; resp_free = 1; step(); resp_valid = 0;
        step();
        chk("r6_late_resp", int'(ty), 10);
        chk("r6_qv", int'(qv), 0);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
